// File: rtl/alu_op_decoder.sv
// RV32I decode stage: instruction word -> ALU control, immediate and datapath enables.
// Registered output with a one-entry skid buffer so in_ready never depends on out_ready.
module alu_op_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] imm,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [4:0]  rd,
    output logic        illegal
);

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] imm;
        logic        src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

    dec_t dec;
    dec_t out_q;
    dec_t skid_q;
    logic out_valid_q;
    logic skid_full_q;

    function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  base_ctrl = 4'd0;
            3'b001:  base_ctrl = 4'd2;
            3'b010:  base_ctrl = 4'd3;
            3'b011:  base_ctrl = 4'd4;
            3'b100:  base_ctrl = 4'd5;
            3'b101:  base_ctrl = 4'd6;
            3'b110:  base_ctrl = 4'd8;
            default: base_ctrl = 4'd9;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] imm_shamt;
    logic        legal;

    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign funct7    = in_instr[31:25];
    assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u     = {in_instr[31:12], 12'b0};
    assign imm_shamt = {27'b0, in_instr[24:20]};

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                dec.rd        = in_instr[11:7];
                if (funct7 == 7'b0000000)
                    dec.ctrl = base_ctrl(funct3);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    dec.ctrl = 4'd1;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    dec.ctrl = 4'd7;
                else
                    legal = 1'b0;
            end
            7'b0010011: begin
                dec.src_imm   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.imm       = imm_i;
                dec.ctrl      = base_ctrl(funct3);
                // Shift immediates carry only the shift amount, funct7 selects srl/sra.
                if (funct3 == 3'b001) begin
                    dec.imm = imm_shamt;
                    if (funct7 != 7'b0000000) legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    dec.imm = imm_shamt;
                    if (funct7 == 7'b0100000)      dec.ctrl = 4'd7;
                    else if (funct7 != 7'b0000000) legal = 1'b0;
                end
            end
            7'b0000011: begin
                dec.src_imm   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.imm       = imm_i;
                case (funct3)
                    3'b000:  dec.ctrl = 4'd10;
                    3'b001:  dec.ctrl = 4'd11;
                    3'b010:  dec.ctrl = 4'd0;
                    3'b100:  dec.ctrl = 4'd12;
                    3'b101:  dec.ctrl = 4'd13;
                    default: legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                dec.src_imm   = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm       = imm_s;
                if (funct3 > 3'b010) legal = 1'b0;
            end
            7'b0110111: begin
                dec.ctrl      = 4'd14;
                dec.src_imm   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.imm       = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.ctrl    = 4'd15;
            dec.illegal = 1'b1;
        end
    end

    logic accept;
    logic xfer;

    assign accept = in_valid & ~skid_full_q;
    assign xfer   = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (skid_full_q) begin
            if (xfer) begin
                out_q       <= skid_q;
                skid_full_q <= 1'b0;
            end
        end else if (!out_valid_q || xfer) begin
            out_valid_q <= accept;
            if (accept) out_q <= dec;
        end else if (accept) begin
            skid_q      <= dec;
            skid_full_q <= 1'b1;
        end
    end

    assign in_ready    = ~skid_full_q;
    assign out_valid   = out_valid_q;
    assign alu_ctrl    = out_q.ctrl;
    assign imm         = out_q.imm;
    assign alu_src_imm = out_q.src_imm;
    assign reg_write   = out_q.reg_write;
    assign mem_read    = out_q.mem_read;
    assign mem_write   = out_q.mem_write;
    assign rd          = out_q.rd;
    assign illegal     = out_q.illegal;

endmodule
